loop_cntr_ctl: RTL and testbench

- Owns the program sequencer's active loop counter register (CNTR).
- Acts as the client/initiator of the loop count stack:
  - pushes the outer loop's count when a nested count is loaded;
  - pops and restores it when the loop exits.
- Decrements CNTR once per counter-loop iteration and flags counter-expire (CE) to the sequencer's loop-termination logic.
- Generates the stack's push/pop strobes, write data and clock-gate request.

---
 rtl/loop_cntr_ctl.sv | 60 ++++++
 tb/tb_loop_cntr_ctl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/loop_cntr_ctl.sv
// loop_cntr_ctl: owns the loop counter CNTR and drives the loop count stack.
// Outer counts are pushed on nested loads and restored from the stack on loop exit.
module loop_cntr_ctl #(
    parameter int CW = 14,
    parameter logic [CW-1:0] INIT_CNT = '0
) (
    input  logic          DSPCLK,
    input  logic          T_RST_,
    input  logic          LdCNTR_EN,
    input  logic [CW-1:0] CNTR_din,
    input  logic          DecCNT_EN,
    input  logic          PopReq,
    input  logic [CW-1:0] TopCNT,
    input  logic          CNT_full,
    input  logic          CNT_empty,
    output logic          PushCNT_EN,
    output logic          PopCNT_EN,
    output logic [CW-1:0] CNTin,
    output logic          CNS_CKenb,
    output logic [CW-1:0] CNTR,
    output logic          CE,
    output logic          CNTR_valid,
    output logic          SOVF,
    output logic          SUNF
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state;
    logic active;
    assign active = state == ACTIVE;
    // Strobes are held off while reset is asserted so the stack is never touched during reset.
    assign PushCNT_EN = T_RST_ & LdCNTR_EN & active & !PopReq & !CNT_full;
    assign PopCNT_EN = T_RST_ & PopReq & !LdCNTR_EN & !CNT_empty;
    assign CNTin = CNTR;
    assign CNS_CKenb = !(PushCNT_EN | PopCNT_EN);
    assign CE = active & (CNTR == CW'(1));
    assign CNTR_valid = active;
    always_ff @(posedge DSPCLK) begin
        if (!T_RST_) begin
            state <= IDLE;
            CNTR <= INIT_CNT;
            SOVF <= 1'b0;
            SUNF <= 1'b0;
        end else if (LdCNTR_EN) begin
            CNTR <= CNTR_din;
            state <= ACTIVE;
            if (active & !PopReq & CNT_full)
                SOVF <= 1'b1;
        end else if (PopReq) begin
            if (!CNT_empty) begin
                CNTR <= TopCNT;
                state <= ACTIVE;
            end else if (active)
                state <= IDLE;
            else
                SUNF <= 1'b1;
        end else if (DecCNT_EN & active) begin
            CNTR <= CNTR - CW'(1);
        end
    end
endmodule

// File: tb/tb_loop_cntr_ctl.sv
// tb_loop_cntr_ctl: directed + random stimulus against a stack-level reference model,
// expectations queued per cycle and checked by an independent monitor.
module tb_loop_cntr_ctl;
    localparam int CW = 14;
    localparam int DEPTH = 4;

    logic DSPCLK = 0, T_RST_ = 0, LdCNTR_EN = 0, DecCNT_EN = 0, PopReq = 0;
    logic CNT_full = 0, CNT_empty = 1;
    logic [CW-1:0] CNTR_din = '0, TopCNT = '0;
    logic PushCNT_EN, PopCNT_EN, CNS_CKenb, CE, CNTR_valid, SOVF, SUNF;
    logic [CW-1:0] CNTin, CNTR;

    loop_cntr_ctl #(.CW(CW), .INIT_CNT('0)) dut (
        .DSPCLK(DSPCLK), .T_RST_(T_RST_), .LdCNTR_EN(LdCNTR_EN), .CNTR_din(CNTR_din),
        .DecCNT_EN(DecCNT_EN), .PopReq(PopReq), .TopCNT(TopCNT), .CNT_full(CNT_full),
        .CNT_empty(CNT_empty), .PushCNT_EN(PushCNT_EN), .PopCNT_EN(PopCNT_EN), .CNTin(CNTin),
        .CNS_CKenb(CNS_CKenb), .CNTR(CNTR), .CE(CE), .CNTR_valid(CNTR_valid), .SOVF(SOVF), .SUNF(SUNF)
    );

    always #5 DSPCLK = ~DSPCLK;

    typedef struct {
        bit rst;
        bit push, pop, ckenb, ce, valid, sovf, sunf;
        logic [CW-1:0] cntin, cntr;
    } exp_t;

    exp_t sb[$];
    logic [CW-1:0] stk[$];
    logic [CW-1:0] m_cnt;
    bit m_valid, m_sovf, m_sunf;
    int tests = 0, fails = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cnt = '0;
        m_valid = 0;
        m_sovf = 0;
        m_sunf = 0;
        stk.delete();
    endtask

    task automatic cyc(bit r, bit ld, logic [CW-1:0] d, bit dc, bit pr);
        exp_t e;
        bit empty, full;
        @(posedge DSPCLK);
        #1;
        empty = stk.size() == 0;
        full = stk.size() == DEPTH;
        T_RST_ = !r;
        LdCNTR_EN = ld;
        CNTR_din = d;
        DecCNT_EN = dc;
        PopReq = pr;
        CNT_empty = empty;
        CNT_full = full;
        TopCNT = empty ? CW'($urandom) : stk[$];
        e.rst = r;
        e.push = ld && m_valid && !pr && !full;
        e.pop = pr && !ld && !empty;
        e.ckenb = !(e.push || e.pop);
        e.cntin = m_cnt;
        e.cntr = m_cnt;
        e.ce = m_valid && m_cnt == 1;
        e.valid = m_valid;
        e.sovf = m_sovf;
        e.sunf = m_sunf;
        sb.push_back(e);
        if (r) m_reset();
        else if (ld) begin
            if (m_valid && !pr) begin
                if (full) m_sovf = 1;
                else stk.push_back(m_cnt);
            end
            m_cnt = d;
            m_valid = 1;
        end else if (pr) begin
            if (!empty) begin
                m_cnt = stk.pop_back();
                m_valid = 1;
            end else if (m_valid) m_valid = 0;
            else m_sunf = 1;
        end else if (dc && m_valid) m_cnt = m_cnt - 1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge DSPCLK);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (!e.rst) begin
                    chk("push", PushCNT_EN, e.push);
                    chk("pop", PopCNT_EN, e.pop);
                    chk("ckenb", CNS_CKenb, e.ckenb);
                    if (e.push) chk("cntin", CNTin, e.cntin);
                end
                chk("cntr", CNTR, e.cntr);
                chk("ce", CE, e.ce);
                chk("valid", CNTR_valid, e.valid);
                chk("sovf", SOVF, e.sovf);
                chk("sunf", SUNF, e.sunf);
            end
        end
    end

    initial begin
        repeat (2) @(posedge DSPCLK);
        m_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 5, 0, 0);
        repeat (5) cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0);
        cyc(0, 1, 7, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 1, CW'(10 + i), 0, 0);
        repeat (DEPTH + 2) cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 4, 0, 0);
        cyc(0, 1, 6, 1, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 9, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [CW-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 2)) : CW'($urandom);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, d,
                $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
        end
        @(negedge DSPCLK);
        #1;
        chk("drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
